wb_trace_checker: RTL and testbench

WB_TRACE_CHECKER -- requirements
Module: wb_trace_checker

---
 rtl/trace_pkg.sv | 36 +++
 rtl/wb_event_fifo.sv | 53 +++++
 rtl/wb_trace_checker.sv | 192 +++++++++++++++++++
 tb/tb_wb_trace_checker.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the writeback trace checker.
// Entries and events share one 87-bit layout.
package trace_pkg;

  typedef enum logic [1:0] {
    K_REG  = 2'd0,
    K_HILO = 2'd1,
    K_SKIP = 2'd2,
    K_END  = 2'd3
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [4:0]  addr;
    logic [63:0] value;
    logic [15:0] cyc;
  } entry_t;

  typedef struct packed {
    kind_e       kind;
    logic [4:0]  addr;
    logic [63:0] value;
    logic [15:0] cyc;
  } event_t;

  localparam int ENTRY_W = 87;
  localparam int EVENT_W = $bits(event_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/wb_event_fifo.sv
// Event FIFO: up to MAX_PUSH packed pushes per cycle,
// one pop per cycle, synchronous clear.
module wb_event_fifo #(
  parameter int W        = 8,
  parameter int DEPTH    = 8,
  parameter int MAX_PUSH = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic [$clog2(MAX_PUSH+1)-1:0]  push_cnt,
  input  logic [MAX_PUSH*W-1:0]          push_data,
  input  logic                           pop,
  output logic [W-1:0]                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(MAX_PUSH+1);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!clear) begin
      for (int i = 0; i < MAX_PUSH; i++) begin
        if (PW'(i) < push_cnt)
          mem[wr_ptr + AW'(i)] <= push_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push_cnt) - CW'(pop);
    end
  end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares live writeback events against an expected
// trace held in an external synchronous memory.
module wb_trace_checker
  import trace_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 8,
  parameter int CHECK_CYC  = 0
) (
  input  logic                       clk_50M,
  input  logic                       reset_btn,
  input  logic                       start,
  input  logic [NUM_CH-1:0]          wb_valid,
  input  logic [NUM_CH*5-1:0]        wb_addr,
  input  logic [NUM_CH*32-1:0]       wb_data,
  input  logic                       hilo_we,
  input  logic [63:0]                hilo_val,
  output logic [$clog2(DEPTH)-1:0]   exp_raddr,
  input  logic [ENTRY_W-1:0]         exp_rdata,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                err_count,
  output logic [$clog2(DEPTH)-1:0]   first_err_idx,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int MP = NUM_CH + 1;
  localparam int PW = $clog2(MP + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [15:0]       cyc_q;
  logic [AW-1:0]     idx_q;
  logic              first_q;
  logic              pass_q;
  logic [PW-1:0]     n_ev;
  logic [PW-1:0]     push_cnt;
  logic [PW-1:0]     drop;
  logic [MP*EVENT_W-1:0] push_flat;
  logic [EVENT_W-1:0] head_raw;
  logic [CW-1:0]     fifo_cnt;
  event_t            ev;
  event_t            head;
  entry_t            ent;
  logic              accept, fit, ovf_evt;
  logic              pop, match, mis;
  logic [17:0]       err_sum;
  logic [15:0]       err_d;

  assign ent  = entry_t'(exp_rdata);
  assign head = event_t'(head_raw);
  assign busy = (state_q == ST_PRIME) || (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign pass = pass_q;
  assign exp_raddr = idx_q + AW'(pop);

  // Pack this cycle's events densely: HI/LO first, then channels.
  always_comb begin
    n_ev      = '0;
    push_flat = '0;
    ev        = '0;
    if (hilo_we) begin
      ev.kind  = K_HILO;
      ev.addr  = '0;
      ev.value = {hilo_val[31:0], hilo_val[63:32]};
      ev.cyc   = cyc_q;
      push_flat[0 +: EVENT_W] = ev;
      n_ev = PW'(1);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (wb_valid[c] && wb_addr[c*5 +: 5] != 5'd0 &&
          wb_data[c*32 +: 32] != 32'd0) begin
        ev.kind  = K_REG;
        ev.addr  = wb_addr[c*5 +: 5];
        ev.value = {32'h0, wb_data[c*32 +: 32]};
        ev.cyc   = cyc_q;
        push_flat[int'(n_ev)*EVENT_W +: EVENT_W] = ev;
        n_ev = n_ev + 1'b1;
      end
    end
  end

  // Free space ignores a same-cycle pop on purpose.
  assign accept = busy && !start;
  assign fit = 16'(n_ev) <=
               (16'(FIFO_DEPTH) - 16'(fifo_cnt));
  assign push_cnt = (accept && fit) ? n_ev : '0;
  assign ovf_evt  = accept && !fit;
  assign drop     = ovf_evt ? n_ev : '0;

  assign pop = (state_q == ST_RUN) && !start &&
               (fifo_cnt != '0) && (ent.kind != K_END);

  always_comb begin
    match = 1'b1;
    unique case (1'b1)
      ent.kind == K_REG:
        match = (head.kind == K_REG) &&
                (head.addr == ent.addr) &&
                (head.value[31:0] == ent.value[31:0]);
      ent.kind == K_HILO:
        match = (head.kind == K_HILO) &&
                (head.value == ent.value);
      default:
        match = 1'b1;
    endcase
    if (CHECK_CYC == 1 && ent.kind != K_SKIP &&
        head.cyc != ent.cyc)
      match = 1'b0;
  end

  assign mis     = pop && !match;
  assign err_sum = 18'(err_count) + 18'(drop) + 18'(mis);
  assign err_d   = (err_sum > 18'hFFFF) ? 16'hFFFF
                                        : err_sum[15:0];

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_PRIME;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_PRIME: state_d = ST_RUN;
        ST_RUN: begin
          if (ent.kind == K_END)
            state_d = ST_DONE;
          else if (pop && idx_q == AW'(DEPTH-1))
            state_d = ST_DONE;
        end
        default:  state_d = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge reset_btn) begin
    if (!reset_btn) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk_50M or negedge reset_btn) begin
    if (!reset_btn) begin
      cyc_q         <= '0;
      idx_q         <= '0;
      err_count     <= '0;
      first_q       <= 1'b0;
      first_err_idx <= '0;
      overflow      <= 1'b0;
      pass_q        <= 1'b0;
    end else if (start) begin
      cyc_q         <= '0;
      idx_q         <= '0;
      err_count     <= '0;
      first_q       <= 1'b0;
      first_err_idx <= '0;
      overflow      <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      if (busy) cyc_q <= cyc_q + 16'd1;
      if (pop)  idx_q <= idx_q + 1'b1;
      err_count <= err_d;
      if (mis && !first_q) begin
        first_q       <= 1'b1;
        first_err_idx <= idx_q;
      end
      if (ovf_evt) overflow <= 1'b1;
      if (state_q == ST_RUN && state_d == ST_DONE)
        pass_q <= (err_d == 16'd0) &&
                  !(overflow || ovf_evt) &&
                  (fifo_cnt == CW'(pop));
    end
  end

  wb_event_fifo #(
    .W        (EVENT_W),
    .DEPTH    (FIFO_DEPTH),
    .MAX_PUSH (MP)
  ) u_fifo (
    .clk       (clk_50M),
    .rst_n     (reset_btn),
    .clear     (start),
    .push_cnt  (push_cnt),
    .push_data (push_flat),
    .pop       (pop),
    .head      (head_raw),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench: three checker instances (default,
// 4-deep FIFO, cycle-checking) fed by one stimulus.
module tb_wb_trace_checker;

  logic        clk_50M = 1'b0;
  logic        reset_btn;
  logic        start;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_addr;
  logic [63:0] wb_data;
  logic        hilo_we;
  logic [63:0] hilo_val;

  logic [86:0] mem [256];
  logic [7:0]  ra_a, ra_b, ra_c;
  logic [86:0] rd_a, rd_b, rd_c;
  logic        a_busy, a_done, a_pass, a_ovf;
  logic        b_busy, b_done, b_pass, b_ovf;
  logic        c_busy, c_done, c_pass, c_ovf;
  logic [15:0] a_err, b_err, c_err;
  logic [7:0]  a_fi, b_fi, c_fi;
  logic [2:0]  dn;

  int total = 0;
  int bad   = 0;

  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) begin
    rd_a <= mem[ra_a];
    rd_b <= mem[ra_b];
    rd_c <= mem[ra_c];
  end

  assign dn = {c_done, b_done, a_done};

  wb_trace_checker dut_a (
    .clk_50M(clk_50M), .reset_btn(reset_btn),
    .start(start), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .hilo_we(hilo_we), .hilo_val(hilo_val),
    .exp_raddr(ra_a), .exp_rdata(rd_a),
    .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_count(a_err), .first_err_idx(a_fi),
    .overflow(a_ovf));

  wb_trace_checker #(.FIFO_DEPTH(4)) dut_b (
    .clk_50M(clk_50M), .reset_btn(reset_btn),
    .start(start), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .hilo_we(hilo_we), .hilo_val(hilo_val),
    .exp_raddr(ra_b), .exp_rdata(rd_b),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .first_err_idx(b_fi),
    .overflow(b_ovf));

  wb_trace_checker #(.CHECK_CYC(1)) dut_c (
    .clk_50M(clk_50M), .reset_btn(reset_btn),
    .start(start), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .hilo_we(hilo_we), .hilo_val(hilo_val),
    .exp_raddr(ra_c), .exp_rdata(rd_c),
    .busy(c_busy), .done(c_done), .pass(c_pass),
    .err_count(c_err), .first_err_idx(c_fi),
    .overflow(c_ovf));

  function automatic logic [86:0] mk(
    input logic [1:0] k, input logic [4:0] a,
    input logic [63:0] v, input logic [15:0] c);
    return {k, a, v, c};
  endfunction

  task automatic tick();
    @(negedge clk_50M);
    hilo_we  = 1'b0;
    hilo_val = '0;
    wb_valid = '0;
    wb_addr  = '0;
    wb_data  = '0;
  endtask

  task automatic set_wb(input int ch, input logic [4:0] a,
                        input logic [31:0] d);
    wb_valid[ch]         = 1'b1;
    wb_addr[ch*5 +: 5]   = a;
    wb_data[ch*32 +: 32] = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int k = 0;
    while (!dn[sel] && k < 200) begin
      @(negedge clk_50M);
      k++;
    end
    total++;
    if (!dn[sel]) begin
      bad++;
      $display("FAIL wait_done dut=%0d got=0 want=1", sel);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({a_busy, a_done, a_pass, a_ovf} !== 4'b0) begin
      bad++;
      $display("FAIL rst_flags got=%b want=0000",
               {a_busy, a_done, a_pass, a_ovf});
    end
    total++;
    if (a_err !== 16'd0) begin
      bad++;
      $display("FAIL rst_err got=%0d want=0", a_err);
    end
    total++;
    if ({a_fi, ra_a} !== 16'd0) begin
      bad++;
      $display("FAIL rst_idx got=%0h want=0", {a_fi, ra_a});
    end
    reset_btn = 1'b1;
    tick();
    hilo_we = 1'b1;
    hilo_val = 64'h5;
    set_wb(0, 5'd1, 32'h1);
    tick();
    tick();
    total++;
    if ({a_busy, a_done, ra_a} !== 10'd0) begin
      bad++;
      $display("FAIL idle_stay got=%0h want=0",
               {a_busy, a_done, ra_a});
    end
  endtask

  task automatic test_single();
    mem[0] = mk(2'd0, 5'd1, 64'h1234, 16'd0);
    mem[1] = mk(2'd0, 5'd2, 64'h10, 16'd0);
    mem[2] = mk(2'd3, 5'd0, 64'h0, 16'd0);
    do_start();
    total++;
    if (a_busy !== 1'b1) begin
      bad++;
      $display("FAIL single_busy got=%b want=1", a_busy);
    end
    set_wb(0, 5'd1, 32'h1234);
    tick();
    set_wb(1, 5'd2, 32'h10);
    tick();
    wait_done(0);
    total++;
    if ({a_pass, a_err} !== {1'b1, 16'd0}) begin
      bad++;
      $display("FAIL single_pass got=%b/%0d want=1/0",
               a_pass, a_err);
    end
  endtask

  task automatic test_mismatch();
    for (int i = 0; i < 4; i++)
      mem[i] = mk(2'd0, 5'(i + 1), 64'(i + 1), 16'd0);
    mem[4] = mk(2'd0, 5'd3, 64'h5, 16'd0);
    mem[5] = mk(2'd3, 5'd0, 64'h0, 16'd0);
    do_start();
    for (int i = 0; i < 4; i++) begin
      set_wb(0, 5'(i + 1), 32'(i + 1));
      tick();
    end
    set_wb(0, 5'd3, 32'h6);
    tick();
    wait_done(0);
    total++;
    if (a_err !== 16'd1) begin
      bad++;
      $display("FAIL mis_err got=%0d want=1", a_err);
    end
    total++;
    if (a_fi !== 8'd4) begin
      bad++;
      $display("FAIL mis_idx got=%0d want=4", a_fi);
    end
    total++;
    if (a_pass !== 1'b0) begin
      bad++;
      $display("FAIL mis_pass got=%b want=0", a_pass);
    end
  endtask

  task automatic drive_dual();
    hilo_we  = 1'b1;
    hilo_val = 64'h00000001_00000002;
    set_wb(0, 5'd4, 32'h7);
    set_wb(1, 5'd5, 32'h8);
    tick();
  endtask

  task automatic test_dual();
    mem[0] = mk(2'd1, 5'd0, 64'h00000002_00000001, 16'd0);
    mem[1] = mk(2'd0, 5'd4, 64'h7, 16'd0);
    mem[2] = mk(2'd0, 5'd5, 64'h8, 16'd0);
    mem[3] = mk(2'd3, 5'd0, 64'h0, 16'd0);
    do_start();
    drive_dual();
    wait_done(0);
    total++;
    if ({a_pass, a_err} !== {1'b1, 16'd0}) begin
      bad++;
      $display("FAIL dual_ok got=%b/%0d want=1/0",
               a_pass, a_err);
    end
    mem[1] = mk(2'd0, 5'd5, 64'h8, 16'd0);
    mem[2] = mk(2'd0, 5'd4, 64'h7, 16'd0);
    do_start();
    drive_dual();
    wait_done(0);
    total++;
    if ({a_pass, a_err} !== {1'b0, 16'd2}) begin
      bad++;
      $display("FAIL dual_swap got=%b/%0d want=0/2",
               a_pass, a_err);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++)
      mem[i] = mk(2'd2, 5'd0, 64'h0, 16'd0);
    mem[3] = mk(2'd3, 5'd0, 64'h0, 16'd0);
    do_start();
    drive_dual();
    drive_dual();
    wait_done(1);
    total++;
    if (b_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_flag got=%b want=1", b_ovf);
    end
    total++;
    if (b_err < 16'd3) begin
      bad++;
      $display("FAIL ovf_err got=%0d want>=3", b_err);
    end
    total++;
    if (b_pass !== 1'b0) begin
      bad++;
      $display("FAIL ovf_pass got=%b want=0", b_pass);
    end
  endtask

  task automatic test_filter_cyc();
    mem[0] = mk(2'd0, 5'd7, 64'h1, 16'd5);
    mem[1] = mk(2'd3, 5'd0, 64'h0, 16'd0);
    do_start();
    set_wb(0, 5'd0, 32'h9);
    set_wb(1, 5'd6, 32'h0);
    tick();
    repeat (5) tick();
    set_wb(0, 5'd7, 32'h1);
    tick();
    wait_done(2);
    total++;
    if ({c_err, c_fi} !== {16'd1, 8'd0}) begin
      bad++;
      $display("FAIL cyc_err got=%0d/%0d want=1/0",
               c_err, c_fi);
    end
    wait_done(0);
    total++;
    if ({a_pass, a_err} !== {1'b1, 16'd0}) begin
      bad++;
      $display("FAIL filter got=%b/%0d want=1/0",
               a_pass, a_err);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++)
      mem[i] = mk(2'd0, 5'(i + 1), 64'(32'h100 + i), 16'd0);
    mem[6] = mk(2'd3, 5'd0, 64'h0, 16'd0);
    do_start();
    for (int i = 0; i < 3; i++) begin
      set_wb(i % 2, 5'(i + 1), 32'h100 + 32'(i));
      tick();
    end
    tick();
    tick();
    total++;
    if ({a_busy, ra_a, a_err} !== {1'b1, 8'd3, 16'd0}) begin
      bad++;
      $display("FAIL mid_progress got=%b/%0d/%0d want=1/3/0",
               a_busy, ra_a, a_err);
    end
    reset_btn = 1'b0;
    #1;
    total++;
    if ({a_busy, a_done, a_pass, a_ovf, a_err, a_fi, ra_a}
        !== 36'd0) begin
      bad++;
      $display("FAIL mid_reset got=%0h want=0",
               {a_busy, a_done, a_pass, a_ovf, a_err, a_fi, ra_a});
    end
    tick();
    reset_btn = 1'b1;
    set_wb(0, 5'd1, 32'h100);
    tick();
    tick();
    total++;
    if ({a_busy, a_done, ra_a} !== 10'd0) begin
      bad++;
      $display("FAIL mid_idle got=%0h want=0",
               {a_busy, a_done, ra_a});
    end
    do_start();
    for (int i = 0; i < 6; i++) begin
      set_wb(0, 5'(i + 1), 32'h100 + 32'(i));
      tick();
    end
    wait_done(0);
    total++;
    if ({a_pass, a_err} !== {1'b1, 16'd0}) begin
      bad++;
      $display("FAIL mid_rerun got=%b/%0d want=1/0",
               a_pass, a_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = mk(2'd3, 5'd0, 64'h0, 16'd0);
    reset_btn = 1'b0;
    start     = 1'b0;
    tick();
    tick();
    test_reset();
    test_single();
    test_mismatch();
    test_dual();
    test_overflow();
    test_filter_cyc();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
